handshake_fifo_buffer: RTL and testbench

Elastic FIFO buffer on a valid/ready dataflow channel. It sits directly downstream of the handshake constant stages and decouples their combinational `outs_valid`/`ctrl_ready` path from the consumer. It stores up to DEPTH tokens and never passes a combinational path from `outs_ready` to `ins_ready`. An optional bypass mode gives zero latency when the buffer is empty.

---
 rtl/handshake_fifo_buffer.sv | 86 ++++++++
 tb/tb_handshake_fifo_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo_buffer.sv
// Elastic valid/ready FIFO buffer, DEPTH slots of DATA_WIDTH bits.
// ins_ready is derived from the registered count only, so there is no
// combinational path from outs_ready (or any input) to ins_ready.
// Optional feature macro: HANDSHAKE_FIFO_BUFFER_BYPASS_EN gives zero-latency
// pass-through when the buffer is empty; default build is a pure registered FIFO.
module handshake_fifo_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AddrW-1:0]      head_q, head_d;
  logic [AddrW-1:0]      tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;

  logic stored_valid;
  logic push;
  logic pop;
`ifdef HANDSHAKE_FIFO_BUFFER_BYPASS_EN
  logic bypass;
`endif

  // Handshake outputs and push/pop qualification.
  always_comb begin
    ins_ready    = (count_q != CntW'(DEPTH));
    stored_valid = (count_q != '0);
`ifdef HANDSHAKE_FIFO_BUFFER_BYPASS_EN
    // Empty buffer forwards the input; a token taken downstream is never stored.
    bypass     = !stored_valid && ins_valid && outs_ready;
    outs_valid = stored_valid ? 1'b1 : ins_valid;
    outs       = stored_valid ? mem_q[head_q] : ins;
    push       = ins_valid && ins_ready && !bypass;
`else
    outs_valid = stored_valid;
    outs       = mem_q[head_q];
    push       = ins_valid && ins_ready;
`endif
    pop = stored_valid && outs_ready;
  end

  // Next-state for storage, pointers and occupancy; pointers wrap naturally.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[tail_q] = ins;
    end
    tail_d = push ? tail_q + AddrW'(1) : tail_q;
    head_d = pop ? head_q + AddrW'(1) : head_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears storage so outs reads 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Self-checking bench for handshake_fifo_buffer (DATA_WIDTH=32, DEPTH=4).
module tb_handshake_fifo_buffer;

  localparam int unsigned Depth = 4;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] outs;
  logic        outs_valid;
  logic        outs_ready;

  int unsigned passed;
  int unsigned total;

  logic [31:0] m_q[$];

  typedef struct packed {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_outs;
  } vec_t;

  vec_t tbl[10];

  handshake_fifo_buffer #(
    .DATA_WIDTH(32),
    .DEPTH     (Depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .outs      (outs),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic ir, input logic ov, input logic [31:0] o);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_outs = o;
    return v;
  endfunction

  // One cycle against the reference model: drive, check at negedge, update, advance.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy);
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_out;
    ins_valid  = iv;
    ins        = d;
    outs_ready = ordy;
    @(negedge clk);
    e_ir  = (m_q.size() != Depth);
    e_ov  = (m_q.size() != 0);
    e_out = e_ov ? m_q[0] : 32'h0;
`ifdef HANDSHAKE_FIFO_BUFFER_BYPASS_EN
    if (m_q.size() == 0) begin
      e_ov  = iv;
      e_out = d;
    end
`endif
    chk("model_ins_ready", {31'd0, ins_ready}, {31'd0, e_ir});
    chk("model_outs_valid", {31'd0, outs_valid}, {31'd0, e_ov});
    if (e_ov) chk("model_outs", outs, e_out);
    if (iv && e_ir) m_q.push_back(d);
    if (e_ov && ordy) void'(m_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst        = 1'b0;
    ins        = '0;
    ins_valid  = 1'b0;
    outs_ready = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs_valid", {31'd0, outs_valid}, 32'd0);
    chk("rst_ins_ready", {31'd0, ins_ready}, 32'd1);
    chk("rst_outs", outs, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

`ifndef HANDSHAKE_FIFO_BUFFER_BYPASS_EN
    // Fill to full with backpressure, reject a 5th token, then drain in order.
    tbl[0] = mk(1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 32'd0);
    tbl[1] = mk(1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 32'd1);
    tbl[2] = mk(1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 32'd1);
    tbl[3] = mk(1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 32'd1);
    tbl[4] = mk(1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 32'd1);
    tbl[5] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd1);
    tbl[6] = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd2);
    tbl[7] = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd3);
    tbl[8] = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd4);
    tbl[9] = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd1);
    for (int i = 0; i < 10; i++) begin
      ins_valid  = tbl[i].iv;
      ins        = tbl[i].d;
      outs_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_ins_ready", i), {31'd0, ins_ready}, {31'd0, tbl[i].exp_ir});
      chk($sformatf("tbl%0d_outs_valid", i), {31'd0, outs_valid}, {31'd0, tbl[i].exp_ov});
      chk($sformatf("tbl%0d_outs", i), outs, tbl[i].exp_outs);
      @(posedge clk);
      #1;
    end
`endif

    // Single token latency.
    ins        = 32'h0000994F;
    ins_valid  = 1'b1;
    outs_ready = 1'b1;
    @(negedge clk);
`ifdef HANDSHAKE_FIFO_BUFFER_BYPASS_EN
    chk("single_same_cycle_valid", {31'd0, outs_valid}, 32'd1);
    chk("single_same_cycle_outs", outs, 32'h0000994F);
`else
    chk("single_not_yet_valid", {31'd0, outs_valid}, 32'd0);
`endif
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
    @(negedge clk);
`ifdef HANDSHAKE_FIFO_BUFFER_BYPASS_EN
    chk("single_not_stored", {31'd0, outs_valid}, 32'd0);
`else
    chk("single_next_valid", {31'd0, outs_valid}, 32'd1);
    chk("single_next_outs", outs, 32'h0000994F);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single_drained", {31'd0, outs_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Streaming 20 incrementing tokens, then drain.
    for (int i = 0; i < 20; i++) step(1'b1, 32'h100 + i, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

    // Backpressure stability with two tokens held.
    step(1'b1, 32'hA1, 1'b0);
    step(1'b1, 32'hA2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b0);
      chk("bp_outs_hold", outs, 32'hA1);
      chk("bp_valid_hold", {31'd0, outs_valid}, 32'd1);
    end

    // Asynchronous reset mid-cycle with two tokens stored.
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_outs_valid", {31'd0, outs_valid}, 32'd0);
    chk("async_rst_ins_ready", {31'd0, ins_ready}, 32'd1);
    chk("async_rst_outs", outs, 32'h0);
    m_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Random valid/ready traffic with wrap-around.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
